// File: rtl/cnn_pkg.sv
// Shared Q-format constants, coefficient map and saturation helpers for the
// CNN feature-extraction stages.
package cnn_pkg;

  localparam int FRAC_BITS_DEF = 16;
  localparam int N_TAPS        = 9;

  localparam logic [3:0] W_ADDR_LAST_TAP = 4'd8;
  localparam logic [3:0] W_ADDR_BIAS     = 4'd9;

  // Largest positive value of a dw-bit signed word, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int dw);
    sat_max = (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Most negative value of a dw-bit signed word, sign-extended to 64 bits.
  function automatic logic [63:0] sat_min(input int dw);
    sat_min = ~sat_max(dw);
  endfunction

endpackage

// File: rtl/window_gen_3x3.sv
// Raster-order 3x3 window builder: two line buffers, the shifting window
// register, row/col counters and the window-complete flag.
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int data_width = 32,
  parameter int width      = 7,
  parameter int height     = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [data_width-1:0]        data_in,
  input  logic                         valid_in,
  output logic [N_TAPS*data_width-1:0] win,
  output logic                         win_valid,
  output logic                         win_last,
  output logic                         frame_open
);

  localparam int DW = data_width;
  localparam int CW = $clog2(width);
  localparam int RW = $clog2(height);
  localparam logic [CW-1:0] COL_LAST = CW'(width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(height - 1);

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [DW-1:0]          lb_top_q [width];
  logic [DW-1:0]          lb_top_d [width];
  logic [DW-1:0]          lb_mid_q [width];
  logic [DW-1:0]          lb_mid_d [width];
  logic [N_TAPS*DW-1:0]   win_q, win_d;
  logic                   win_valid_q, win_valid_d;
  logic                   win_last_q, win_last_d;
  logic                   open_q, open_d;
  logic                   last_pix_s;

  // Next-state for counters, line buffers and window on an accepted pixel.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    lb_top_d    = lb_top_q;
    lb_mid_d    = lb_mid_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    open_d      = open_q;
    last_pix_s  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_d[(3*r)*DW +: DW]   = win_q[(3*r+1)*DW +: DW];
        win_d[(3*r+1)*DW +: DW] = win_q[(3*r+2)*DW +: DW];
      end
      // Newest column: two rows back on top, current pixel at the bottom.
      win_d[2*DW +: DW] = lb_top_q[col_q];
      win_d[5*DW +: DW] = lb_mid_q[col_q];
      win_d[8*DW +: DW] = data_in;
      lb_top_d[col_q]   = lb_mid_q[col_q];
      lb_mid_d[col_q]   = data_in;
      win_valid_d       = (row_q >= RW'(2)) && (col_q >= CW'(2));
      win_last_d        = last_pix_s;
      open_d            = !last_pix_s;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      open_d = open_q;
    end
  end

  // Window-stage state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      open_q      <= 1'b0;
      for (int i = 0; i < width; i++) begin
        lb_top_q[i] <= '0;
        lb_mid_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      open_q      <= open_d;
      lb_top_q    <= lb_top_d;
      lb_mid_q    <= lb_mid_d;
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_open = open_q;

endmodule

// File: rtl/conv3x3_relu.sv
// Streaming 3x3 convolution with bias, ReLU and saturation. Three stages:
// window capture, registered multiplies, then sum/shift/clamp into data_out.
module conv3x3_relu
  import cnn_pkg::*;
#(
  parameter int data_width = 32,
  parameter int frac_bits  = FRAC_BITS_DEF,
  parameter int width      = 7,
  parameter int height     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  w_wr_en,
  input  logic [3:0]            w_addr,
  input  logic [data_width-1:0] w_data,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int DW = data_width;
  localparam int PW = 2 * data_width;
  localparam int AW = 2 * data_width + 4;
  localparam logic signed [AW-1:0] RES_MAX = AW'(sat_max(DW));

  logic [N_TAPS*DW-1:0] win;
  logic                 win_valid, win_last, frame_open;

  logic [N_TAPS*DW-1:0] coef_q, coef_d;
  logic [DW-1:0]        bias_q, bias_d;
  logic [N_TAPS*PW-1:0] prod_q, prod_d;
  logic                 prod_valid_q, prod_valid_d;
  logic                 prod_last_q, prod_last_d;
  logic [DW-1:0]        data_out_q, data_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 frame_done_q, frame_done_d;

  logic signed [PW-1:0] tap_s, cw_s, mul_s;
  logic signed [AW-1:0] acc_s, res_s;
  logic [DW-1:0]        clamp_s;

  window_gen_3x3 #(
    .data_width(data_width),
    .width     (width),
    .height    (height)
  ) u_win (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .win       (win),
    .win_valid (win_valid),
    .win_last  (win_last),
    .frame_open(frame_open)
  );

  assign busy = frame_open | win_valid | prod_valid_q | valid_out_q;

  // Coefficient port; writes while a frame is in flight are dropped.
  always_comb begin
    coef_d = coef_q;
    bias_d = bias_q;
    if (w_wr_en && !busy) begin
      if (w_addr == W_ADDR_BIAS) begin
        bias_d = w_data;
      end else if (w_addr <= W_ADDR_LAST_TAP) begin
        coef_d[int'(w_addr)*DW +: DW] = w_data;
      end else begin
        bias_d = bias_q;
      end
    end else begin
      bias_d = bias_q;
    end
  end

  // S1: nine full-width signed products.
  always_comb begin
    prod_d      = prod_q;
    tap_s       = '0;
    cw_s        = '0;
    mul_s       = '0;
    prod_valid_d = win_valid;
    prod_last_d  = win_valid & win_last;
    for (int k = 0; k < N_TAPS; k++) begin
      tap_s = PW'($signed(win[k*DW +: DW]));
      cw_s  = PW'($signed(coef_q[k*DW +: DW]));
      mul_s = tap_s * cw_s;
      prod_d[k*PW +: PW] = mul_s;
    end
  end

  // S2: bias-aligned sum, floor shift back to Q format, ReLU and clamp.
  always_comb begin
    acc_s = AW'($signed(bias_q)) <<< frac_bits;
    for (int k = 0; k < N_TAPS; k++) begin
      acc_s = acc_s + AW'($signed(prod_q[k*PW +: PW]));
    end
    res_s = acc_s >>> frac_bits;
    if (res_s[AW-1]) begin
      clamp_s = '0;
    end else if (res_s > RES_MAX) begin
      clamp_s = RES_MAX[DW-1:0];
    end else begin
      clamp_s = res_s[DW-1:0];
    end
    valid_out_d  = prod_valid_q;
    frame_done_d = prod_valid_q & prod_last_q;
    if (prod_valid_q) begin
      data_out_d = clamp_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Coefficient and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_q       <= '0;
      bias_q       <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      coef_q       <= coef_d;
      bias_q       <= bias_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      prod_last_q  <= prod_last_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/conv3x3_relu.md
# conv3x3_relu

Streaming 3×3 convolution stage with bias, ReLU and saturation, placed directly upstream of `Max_pooling` in the feature-extraction chain. It accepts one feature-map pixel per `valid_in` beat in raster order and builds a 3×3 window from two internal row buffers. For every complete window it emits one rectified result on `data_out`/`valid_out`, in the same width and raster format that `Max_pooling` consumes. Kernel weights and bias are loaded through a small register-write port between frames.

## Interface
- `data_width`, 32: signed fixed-point pixel, weight and output width.
- `frac_bits`, 16: fractional bits (Q16.16 at default).
- `width`, 7: input feature-map width in pixels (≥3).
- `height`, 7: input feature-map height in pixels (≥3).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `data_in` input `data_width`: input pixel, signed.
- `valid_in` input 1: `data_in` is valid this cycle; there is no back-pressure.
- `w_wr_en` input 1: coefficient write strobe.
- `w_addr` input 4: addresses 0–8 select kernel weights (row-major, 0 = top-left); address 9 selects the bias; addresses 10–15 are ignored.
- `w_data` input `data_width`: coefficient value, signed, same Q format as pixels.
- `data_out` output `data_width`: convolution result after ReLU, registered.
- `valid_out` output 1: `data_out` is valid, one-cycle pulse per result.
- `frame_done` output 1: one-cycle pulse coincident with the last result of a frame.
- `busy` output 1: high while a frame is partially received or the pipeline holds valid data.

## Operation
- Counters `col` (0..width-1) and `row` (0..height-1) advance only on `valid_in`.
  - `col` wraps to 0 and increments `row`.
  - After the pixel at (height-1, width-1), both counters return to 0 and the next frame starts.
- Line buffers hold two rows of `width` pixels; the 3×3 window register shifts only on `valid_in`.
- A window is complete when an accepted pixel has `row≥2` and `col≥2`. This gives valid convolution only, with no padding: (width-2)×(height-2) results per frame.
- Arithmetic:
  - Each product is `2*data_width` signed.
  - Sum = 9 products + (bias <<< `frac_bits`), accumulated in `2*data_width+4` bits.
  - The sum is arithmetic-shifted right by `frac_bits` (truncation toward −∞).
  - ReLU: a negative result becomes 0.
  - A result above 2^(data_width-1)-1 saturates to that maximum.
- Coefficient writes are accepted only when `busy`=0 and ignored when `busy`=1, so the kernel stays constant within a frame.
- Reset: counters, window, line buffers, weights, bias and all outputs go to 0.

## Timing
- Pipeline:
  - S0: window capture on the accepted pixel.
  - S1: 9 registered multiplies.
  - S2: adder tree, shift, ReLU and saturation into the `data_out` register.
- Latency: `valid_out` rises exactly 3 clocks after the `valid_in` edge that completes a window.
  - The valid bits advance every cycle regardless of `valid_in`, so gaps in the input stream do not stretch the latency.
- Throughput: one result per clock with back-to-back `valid_in`.
- `data_out` holds its last value when `valid_out`=0.
- `frame_done` asserts in the same cycle as the `valid_out` of window (height-1, width-1).
- `busy` rises on the first accepted pixel of a frame. It falls the cycle after the final `valid_out` of the frame.
- Asynchronous reset mid-frame:
  - Partial window state and in-flight results are discarded, and `valid_out` is 0 immediately.
  - The next accepted pixel is treated as (0,0).
- A new frame may start immediately after the last pixel of the previous one. Its first pixel may overlap pipeline drain; `busy` stays high.

## Structure
- Shared package `cnn_pkg`: Q-format constants (`frac_bits` default), saturation limit functions, and coefficient address constants (`W_ADDR_BIAS`=9).
- Sub-module `window_gen_3x3`: line buffers, window register, `row`/`col` counters and window-complete flag. The top level holds the coefficients, the MAC pipeline and the output logic.

## Test plan
- Identity kernel (w4=1.0, others 0, bias 0) with a 7×7 ramp of integer pixels 0..48 in Q16.16 -> 25 outputs equal to the centre pixels 8..12, 15..19, 22..26, 29..33, 36..40. `frame_done` is high on the value 40.
- All-ones kernel, all pixels 1.0, bias 0.5 -> every output is 9.5 (0x00098000). Each `valid_out` occurs 3 cycles after its completing `valid_in`.
- Bias −100.0 with the all-ones kernel and pixels 1.0 -> all outputs 0 (ReLU). All-ones kernel with pixels 0x7FFF0000 -> output 0x7FFFFFFF (saturation).
- Random `valid_in` gaps (30% idle) over two back-to-back frames -> results are bit-identical to the gap-free run, with 25 `valid_out` pulses per frame.
- `w_wr_en` asserted while `busy`=1 -> the coefficient is unchanged and the outputs match the prior kernel. The same write with `busy`=0 takes effect.
- Assert `reset` after 20 pixels -> all outputs go to 0 at once. A fresh 7×7 frame then produces the expected 25 results with zeroed weights (all outputs 0) until the coefficients are reloaded.
